// File: rtl/fir_tap_mem.sv
// Coefficient RAM plus circular sample history for the FIR MAC.
// Every accepted sample streams num_taps (h[k], x[n-k]) pairs, newest sample first.
module fir_tap_mem #(
  parameter int DATA_WIDTH      = 32,
  parameter int TAP_ADDR_WIDTH  = 4,
  parameter int HIST_ADDR_WIDTH = 6,
  parameter     INIT_FILE       = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coef_we,
  input  logic [TAP_ADDR_WIDTH-1:0] coef_waddr,
  input  logic [DATA_WIDTH-1:0]     coef_wdata,
  input  logic [TAP_ADDR_WIDTH:0]   num_taps,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_h,
  output logic [DATA_WIDTH-1:0]     m_x,
  output logic                      m_first,
  output logic                      m_last,
  output logic                      busy
);

  localparam int MAX_TAPS   = 1 << TAP_ADDR_WIDTH;
  localparam int HIST_DEPTH = 1 << HIST_ADDR_WIDTH;
  localparam int TW         = TAP_ADDR_WIDTH + 1;
  localparam int CW         = HIST_ADDR_WIDTH + 1;

  localparam logic [TW-1:0]              TAP_ONE  = TW'(1);
  localparam logic [TW-1:0]              TAP_MAX  = TW'(MAX_TAPS);
  localparam logic [HIST_ADDR_WIDTH-1:0] PTR_ONE  = HIST_ADDR_WIDTH'(1);
  localparam logic [CW-1:0]              FILL_ONE = CW'(1);
  localparam logic [CW-1:0]              FILL_MAX = CW'(HIST_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [DATA_WIDTH-1:0] coef_mem [MAX_TAPS];
  logic [DATA_WIDTH-1:0] hist_mem [HIST_DEPTH];

  state_t                     state_q,   state_d;
  logic [HIST_ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
  logic [HIST_ADDR_WIDTH-1:0] newest_q,  newest_d;
  logic [CW-1:0]              fill_q,    fill_d;
  logic [TW-1:0]              n_q,       n_d;
  logic [TW-1:0]              k_q,       k_d;
  logic                       m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]      m_h_q,     m_h_d;
  logic [DATA_WIDTH-1:0]      m_x_q,     m_x_d;
  logic                       m_first_q, m_first_d;
  logic                       m_last_q,  m_last_d;

  logic                       accept;
  logic [TW-1:0]              n_clamped;
  logic [TAP_ADDR_WIDTH-1:0]  k_idx;
  logic [HIST_ADDR_WIDTH-1:0] hist_idx;
  logic [CW-1:0]              k_fill;

  assign accept   = (state_q == IDLE) && s_valid;
  // k never exceeds MAX_TAPS-1 when used as an address, so the low bits suffice.
  assign k_idx    = k_q[TAP_ADDR_WIDTH-1:0];
  assign hist_idx = newest_q - HIST_ADDR_WIDTH'(k_idx);
  assign k_fill   = CW'(k_q);

  always_comb begin
    n_clamped = num_taps;
    if (num_taps == '0)
      n_clamped = TAP_ONE;
    else if (num_taps > TAP_MAX)
      n_clamped = TAP_MAX;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    newest_d  = newest_q;
    fill_d    = fill_q;
    n_d       = n_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    m_h_d     = m_h_q;
    m_x_d     = m_x_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d  = RUN;
          newest_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
          n_d      = n_clamped;
          k_d      = '0;
        end
      end
      RUN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
        end else if ((!m_valid_q || m_ready) && (k_q != n_q)) begin
          m_valid_d = 1'b1;
          m_h_d     = coef_mem[k_idx];
          // Positions never written since reset read as zero.
          m_x_d     = (k_fill >= fill_q) ? '0 : hist_mem[hist_idx];
          m_first_d = (k_q == '0);
          m_last_d  = (k_q == n_q - TAP_ONE);
          k_d       = k_q + TAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      fill_q    <= '0;
      n_q       <= TAP_ONE;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      m_h_q     <= '0;
      m_x_q     <= '0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      fill_q    <= fill_d;
      n_q       <= n_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      m_h_q     <= m_h_d;
      m_x_q     <= m_x_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[coef_waddr] <= coef_wdata;
    if (rst_n && accept) hist_mem[wr_ptr_q] <= s_data;
  end

  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign m_valid = m_valid_q;
  assign m_h     = m_h_q;
  assign m_x     = m_x_q;
  assign m_first = m_first_q;
  assign m_last  = m_last_q;

endmodule
